sc_statemachine_lanes: RTL and testbench

Multi-lane background scheduler for the game's scrolling play field. It generalises the single-lane background state machine to LANES independent lanes. Each lane has its own programmable shift period and direction. A round-robin arbiter issues at most one registered shift command per clock to the lane shift-register bank. The block sits between the start/pause user inputs and the background register datapath.

---
 rtl/sc_statemachine_lanes.sv | 130 +++++++++++++
 tb/tb_sc_statemachine_lanes.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_statemachine_lanes.sv
// Multi-lane background scheduler: start/pause FSM, per-lane period timers and a
// round-robin arbiter issuing at most one registered shift command per clock.
module sc_statemachine_lanes #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     SC_STATEMACHINEBACKG_CLOCK_50,
  input  logic                     SC_STATEMACHINEBACKG_RESET_InHigh,
  input  logic                     startButton_InLow,
  input  logic                     pause_InHigh,
  input  logic [LANES*CNT_W-1:0]   period_In,
  input  logic [LANES-1:0]         dir_In,
  output logic                     clear_OutLow,
  output logic                     shift_Out,
  output logic [LANE_W-1:0]        shiftLane_Out,
  output logic [1:0]               shiftselection_Out,
  output logic                     running_Out,
  output logic [LANES-1:0]         missed_Out
);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_START = 3'd1,
    S_IDLE  = 3'd2,
    S_INIT  = 3'd3,
    S_HOLD  = 3'd4,
    S_RUN   = 3'd5,
    S_PAUSE = 3'd6
  } state_t;

  state_t                        state;
  logic [LANES-1:0][CNT_W-1:0]   counter;
  logic [LANES-1:0]              pending;
  logic [LANES-1:0]              expire;
  logic [LANE_W-1:0]             ptr;
  logic [LANE_W-1:0]             grant_idx;
  logic [LANE_W-1:0]             lane_idx;
  logic                          grant_valid;

  assign clear_OutLow = (state != S_RESET) && (state != S_INIT);
  assign running_Out  = (state == S_RUN) || (state == S_PAUSE);

  // Search starts just after the last granted lane and wraps modulo LANES.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    lane_idx    = '0;
    for (int unsigned k = 1; k <= LANES; k++) begin
      lane_idx = LANE_W'((32'(ptr) + k) % LANES);
      if (!grant_valid && pending[lane_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = lane_idx;
      end
    end
  end

  always_comb begin
    expire = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      expire[i] = (period_In[i*CNT_W +: CNT_W] != '0) && (counter[i] == CNT_W'(1));
    end
  end

  always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
    if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
      state              <= S_RESET;
      counter            <= '0;
      pending            <= '0;
      missed_Out         <= '0;
      ptr                <= LANE_W'(LANES - 1);
      shift_Out          <= 1'b0;
      shiftLane_Out      <= '0;
      shiftselection_Out <= 2'b11;
    end else begin
      shift_Out          <= 1'b0;
      shiftselection_Out <= 2'b11;
      case (state)
        S_RESET: state <= S_START;
        S_START: state <= S_IDLE;
        S_IDLE:  if (!startButton_InLow) state <= S_INIT;
        S_INIT: begin
          for (int unsigned i = 0; i < LANES; i++) begin
            counter[i] <= period_In[i*CNT_W +: CNT_W];
          end
          pending    <= '0;
          missed_Out <= '0;
          ptr        <= LANE_W'(LANES - 1);
          state      <= S_HOLD;
        end
        S_HOLD:  if (startButton_InLow) state <= S_RUN;
        S_RUN: begin
          if (!startButton_InLow) begin
            state <= S_INIT;
          end else begin
            if (pause_InHigh) state <= S_PAUSE;
            // A lane expiring while granted keeps its pending bit: the new request replaces the served one.
            for (int unsigned i = 0; i < LANES; i++) begin
              if (period_In[i*CNT_W +: CNT_W] == '0) begin
                counter[i] <= '0;
              end else if (counter[i] <= CNT_W'(1)) begin
                counter[i] <= period_In[i*CNT_W +: CNT_W];
              end else begin
                counter[i] <= counter[i] - CNT_W'(1);
              end
              if (expire[i]) begin
                pending[i] <= 1'b1;
                if (pending[i] && !(grant_valid && grant_idx == LANE_W'(i))) missed_Out[i] <= 1'b1;
              end else if (grant_valid && grant_idx == LANE_W'(i)) begin
                pending[i] <= 1'b0;
              end
            end
            if (grant_valid) begin
              shift_Out          <= 1'b1;
              shiftLane_Out      <= grant_idx;
              shiftselection_Out <= dir_In[grant_idx] ? 2'b01 : 2'b10;
              ptr                <= grant_idx;
            end
          end
        end
        S_PAUSE: begin
          if (!startButton_InLow) state <= S_INIT;
          else if (!pause_InHigh) state <= S_RUN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_statemachine_lanes.sv
// Bench for sc_statemachine_lanes: directed vector table, pause/restart sequences and
// randomized traffic compared every cycle against a behavioural lane/arbiter model.
module tb_sc_statemachine_lanes;
  localparam int LANES  = 4;
  localparam int LANE_W = 2;
  localparam int CNT_W  = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start_n = 1'b1;
  logic                   pause = 1'b0;
  logic [LANES*CNT_W-1:0] period = '0;
  logic [LANES-1:0]       dir = '0;
  logic                   clear_n, shift, running;
  logic [LANE_W-1:0]      lane;
  logic [1:0]             sel;
  logic [LANES-1:0]       missed;

  sc_statemachine_lanes #(.LANES(LANES), .LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
    .SC_STATEMACHINEBACKG_CLOCK_50    (clk),
    .SC_STATEMACHINEBACKG_RESET_InHigh(rst),
    .startButton_InLow                (start_n),
    .pause_InHigh                     (pause),
    .period_In                        (period),
    .dir_In                           (dir),
    .clear_OutLow                     (clear_n),
    .shift_Out                        (shift),
    .shiftLane_Out                    (lane),
    .shiftselection_Out               (sel),
    .running_Out                      (running),
    .missed_Out                       (missed)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural reference: elapsed ticks per lane, pending flags, last-served lane.
  typedef enum {M_RESET, M_START, M_IDLE, M_INIT, M_HOLD, M_RUN, M_PAUSE} mode_t;
  mode_t      m_mode;
  int         per[LANES];
  int         elapsed[LANES];
  bit         pend[LANES];
  int         last;
  logic [3:0] e_miss;
  bit         e_shift;
  int         e_lane;
  logic [1:0] e_sel;

  function automatic int pcur(input int i);
    return int'(period[i*CNT_W +: CNT_W]);
  endfunction

  task automatic model_reset();
    m_mode = M_RESET;
    for (int i = 0; i < LANES; i++) begin
      per[i] = 0; elapsed[i] = 0; pend[i] = 0;
    end
    e_miss = '0; last = LANES - 1; e_shift = 0; e_lane = 0; e_sel = 2'b11;
  endtask

  task automatic run_step();
    int g = -1;
    bit fired;
    for (int k = 1; k <= LANES; k++) begin
      if (g < 0 && pend[(last + k) % LANES]) g = (last + k) % LANES;
    end
    for (int i = 0; i < LANES; i++) begin
      fired = 0;
      if (per[i] != 0) begin
        if (elapsed[i] == per[i] - 1) begin
          fired = 1; elapsed[i] = 0; per[i] = pcur(i);
        end else begin
          elapsed[i]++;
        end
      end
      if (fired) begin
        if (pend[i] && i != g) e_miss[i] = 1'b1;
        pend[i] = 1;
      end else if (i == g) begin
        pend[i] = 0;
      end
    end
    if (g >= 0) begin
      e_shift = 1; e_lane = g; e_sel = dir[g] ? 2'b01 : 2'b10; last = g;
    end
  endtask

  task automatic model_edge();
    e_shift = 0; e_sel = 2'b11;
    case (m_mode)
      M_RESET: m_mode = M_START;
      M_START: m_mode = M_IDLE;
      M_IDLE:  if (!start_n) m_mode = M_INIT;
      M_INIT: begin
        for (int i = 0; i < LANES; i++) begin
          per[i] = pcur(i); elapsed[i] = 0; pend[i] = 0;
        end
        e_miss = '0; last = LANES - 1; m_mode = M_HOLD;
      end
      M_HOLD:  if (start_n) m_mode = M_RUN;
      M_RUN: begin
        if (!start_n) m_mode = M_INIT;
        else begin
          if (pause) m_mode = M_PAUSE;
          run_step();
        end
      end
      M_PAUSE: begin
        if (!start_n) m_mode = M_INIT;
        else if (!pause) m_mode = M_RUN;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic cyc();
    logic exp_clear, exp_run;
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    exp_clear = !(m_mode == M_RESET || m_mode == M_INIT);
    exp_run   = (m_mode == M_RUN || m_mode == M_PAUSE);
    chk("model", {clear_n, shift, lane, sel, running, missed},
        {exp_clear, e_shift, 2'(e_lane), e_sel, exp_run, e_miss});
  endtask

  task automatic start_run();
    start_n = 1'b0;
    cyc();
    chk("init_clear", 32'(clear_n), 32'd0);
    start_n = 1'b1;
    cyc();
    chk("hold_clear", 32'(clear_n), 32'd1);
    cyc();
    chk("run_entry", 32'(running), 32'd1);
  endtask

  typedef struct {
    logic [31:0] per;
    logic [3:0]  dir;
    int          cycle;
    logic        shift;
    logic [1:0]  lane;
    logic [1:0]  sel;
    logic [3:0]  miss;
  } vec_t;
  vec_t vt[14];

  initial begin
    logic seen;
    logic [31:0] pv;
    int j;

    vt[0]  = '{32'h00000003, 4'b0000,  3, 1'b0, 2'd0, 2'b11, 4'b0000};
    vt[1]  = '{32'h00000003, 4'b0000,  4, 1'b1, 2'd0, 2'b10, 4'b0000};
    vt[2]  = '{32'h00000003, 4'b0000,  7, 1'b1, 2'd0, 2'b10, 4'b0000};
    vt[3]  = '{32'h00000003, 4'b0000,  9, 1'b0, 2'd0, 2'b11, 4'b0000};
    vt[4]  = '{32'h00000003, 4'b0000, 10, 1'b1, 2'd0, 2'b10, 4'b0000};
    vt[5]  = '{32'h04040404, 4'b1010,  5, 1'b1, 2'd0, 2'b10, 4'b0000};
    vt[6]  = '{32'h04040404, 4'b1010,  6, 1'b1, 2'd1, 2'b01, 4'b0000};
    vt[7]  = '{32'h04040404, 4'b1010,  7, 1'b1, 2'd2, 2'b10, 4'b0000};
    vt[8]  = '{32'h04040404, 4'b1010,  8, 1'b1, 2'd3, 2'b01, 4'b0000};
    vt[9]  = '{32'h04040404, 4'b1010,  9, 1'b1, 2'd0, 2'b10, 4'b0000};
    vt[10] = '{32'h04040404, 4'b1010, 12, 1'b1, 2'd3, 2'b01, 4'b0000};
    vt[11] = '{32'h00000101, 4'b0000,  2, 1'b1, 2'd0, 2'b10, 4'b0010};
    vt[12] = '{32'h00000101, 4'b0000,  3, 1'b1, 2'd1, 2'b10, 4'b0011};
    vt[13] = '{32'h00000101, 4'b0000,  8, 1'b1, 2'd0, 2'b10, 4'b0011};

    // Boot
    model_reset();
    repeat (3) cyc();
    chk("rst_clear", 32'(clear_n), 32'd0);
    chk("rst_outs", {shift, lane, sel, running, missed}, {1'b0, 2'd0, 2'b11, 1'b0, 4'b0000});
    rst = 1'b0;
    #1 chk("reset_state_clear", 32'(clear_n), 32'd0);
    cyc();
    chk("start_clear", 32'(clear_n), 32'd1);
    cyc();
    chk("idle_outs", {shift, sel, running}, {1'b0, 2'b11, 1'b0});

    // Directed vector table
    for (int n = 0; n < 14; n++) begin
      period = vt[n].per;
      dir    = vt[n].dir;
      start_run();
      repeat (vt[n].cycle) cyc();
      chk($sformatf("vec%0d", n), {shift, lane, sel, missed},
          {vt[n].shift, vt[n].lane, vt[n].sel, vt[n].miss});
    end

    // Pause for 10 cycles from RUN cycle 2 delays the first pulse from 6 to 16
    period = 32'h00000005; dir = '0;
    start_run();
    repeat (2) cyc();
    pause = 1'b1;
    seen = 1'b0;
    for (int c = 3; c <= 15; c++) begin
      cyc();
      if (c == 7) chk("pause_running", {running, clear_n}, 2'b11);
      if (c == 12) pause = 1'b0;
      seen = seen | shift;
    end
    chk("pause_no_shift", 32'(seen), 32'd0);
    cyc();
    chk("pause_first_pulse", {shift, lane, sel}, {1'b1, 2'd0, 2'b10});

    // Restart with start held 6 cycles during an overrun
    period = 32'h00000101; dir = '0;
    start_run();
    repeat (6) cyc();
    chk("pre_restart_miss", 32'(missed), 32'h3);
    start_n = 1'b0;
    cyc();
    chk("restart_init", {clear_n, shift}, 2'b00);
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      seen = seen | shift | running | !clear_n | (missed != 0);
    end
    chk("restart_hold_quiet", 32'(seen), 32'd0);
    start_n = 1'b1;
    repeat (3) cyc();
    chk("restart_lane0_first", {shift, lane}, {1'b1, 2'd0});

    // Randomized traffic against the model
    for (int r = 0; r < 12; r++) begin
      pv = '0;
      for (int i = 0; i < LANES; i++) begin
        if ($urandom_range(0, 2) != 0) pv[i*CNT_W +: CNT_W] = 8'($urandom_range(1, 7));
      end
      period = pv;
      dir = 4'($urandom);
      start_run();
      repeat (60) begin
        if ($urandom_range(0, 9) == 0) pause = ~pause;
        start_n = ($urandom_range(0, 59) != 0);
        if ($urandom_range(0, 19) == 0) begin
          j = $urandom_range(0, LANES - 1);
          if (period[j*CNT_W +: CNT_W] != '0) period[j*CNT_W +: CNT_W] = 8'($urandom_range(1, 7));
        end
        cyc();
      end
      if (r == 6) begin
        rst = 1'b1;
        #1;
        chk("async_rst", {clear_n, shift, lane, sel, running, missed},
            {1'b0, 1'b0, 2'd0, 2'b11, 1'b0, 4'b0000});
        model_reset();
        repeat (2) cyc();
        rst = 1'b0;
      end
      pause = 1'b0;
      start_n = 1'b1;
      repeat (2) cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
